mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Bus initiator for the 8-bit single-port RAM. It drives that RAM's address, write-enable and output-enable lines and its shared tri-state data bus.
- Accepts single or burst read/write requests from the control unit through a valid/ready handshake.
- Returns read data as a registered response stream, tracking the RAM's one-cycle registered read latency.
- Bursts are pipelined at one beat per cycle.

Parameters:
- LEN_W, 4, width of req_len; burst length = req_len+1 beats (1..16).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on posedge when req_valid && req_ready.
- req_we  in  1  1 = write (fill), 0 = read.
- req_addr  in  8  start address.
- req_wdata  in  8  write data; the same byte is written to every beat of a write burst.
- req_len  in  LEN_W  beats minus one.
- rsp_valid  out  1  one-cycle pulse per read beat, registered.
- rsp_data  out  8  read byte, valid while rsp_valid.
- rsp_last  out  1  high with rsp_valid on the final read beat.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse, address-wrap error (see Optional Feature).
- mem_addr  out  8  RAM address.
- mem_we  out  1  RAM write enable.
- mem_oe  out  1  RAM output enable.
- mem_data  inout  8  shared bus; driven by this block only while mem_we=1, else 'bz.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - mem_we, mem_oe, rsp_valid, rsp_last and err are 0; mem_addr and rsp_data are 0x00.
  - mem_data is released at once.
  - Any in-flight burst is abandoned; no further rsp beats are produced.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready=1, mem_we=0, mem_oe=0.
  - On accept, latch addr, wdata and the beat counter (req_len).
  - Go to WRITE if req_we=1, else READ.
- WRITE:
  - Each cycle: mem_addr=current addr, mem_we=1, mem_oe=0, mem_data=latched wdata. The RAM commits on the next posedge.
  - Address increments by 1 mod 256 each cycle (0xFF wraps to 0x00); the counter decrements.
  - After the final beat, go to IDLE. No response is produced for writes.
- READ:
  - Each cycle: mem_addr=current addr, mem_we=0, mem_oe=1.
  - Address increments and the counter decrements as in WRITE.
  - After the last address cycle, go to DRAIN.
- DRAIN:
  - One cycle with mem_oe=1 and mem_we=0, then IDLE.
- Read datapath:
  - The RAM latches mem[addr] at the posedge ending address cycle n and drives the bus during cycle n+1.
  - The block samples mem_data at the posedge ending cycle n+1 and registers it into rsp_data with rsp_valid=1 for cycle n+2.
  - Latency: request accepted at edge k → first rsp_valid in the cycle after edge k+2. Beats follow on consecutive cycles with no gaps.
  - rsp_last is asserted on beat req_len.
- There is no response backpressure; the consumer must take every beat.
- Back-to-back requests:
  - req_ready returns high in the cycle after WRITE or DRAIN ends.
  - Minimum idle gap between requests is one cycle.
- Bus contention: never. The RAM drives only when oe && !we, and this block drives only with mem_we=1 and mem_oe=0.
- The final rsp beat of a read may appear in the same cycle as IDLE (req_ready=1). This is legal.
- req_valid while busy is ignored and not queued.

Optional Feature:
- Macro MEM_MASTER_WRAP_ERR_EN.
- Defined:
  - A burst whose next address would wrap from 0xFF to 0x00 terminates after the 0xFF beat. The counter is forced to zero.
  - Reads: that beat carries rsp_last, and err pulses together with its rsp_valid.
  - Writes: err pulses in the cycle after the 0xFF write.
- Undefined: addresses wrap silently and err is tied 0.

Test Plan:
- Write req_addr=0x10, req_wdata=0xAB, len=0, then read 0x10 len=0 → exactly one write cycle with mem_addr=0x10, mem_we=1, mem_data=0xAB; rsp_valid=1, rsp_data=0xAB, rsp_last=1 in the cycle after edge k+2 of the read accept.
- Fill write addr=0x20, wdata=0x5A, len=3, then read 0x20 len=3 → writes 0x20..0x23 on 4 consecutive cycles; 4 contiguous rsp beats of 0x5A, rsp_last on the 4th; busy low after DRAIN.
- Read addr=0xFE, len=3, RAM preloaded with 0xFE=1, 0xFF=2, 0x00=3, 0x01=4 → without macro: mem_addr sequence FE, FF, 00, 01; rsp 1, 2, 3, 4. With MEM_MASTER_WRAP_ERR_EN: rsp 1, 2 only, rsp_last and err on beat 2.
- Assert req_valid continuously during a len=7 read → req_ready=0 throughout the burst; the second request is accepted only after DRAIN; no beats are lost or duplicated.
- Drive rst_n low mid-way through an 8-beat read → mem_oe, mem_we, rsp_valid and busy drop to 0 asynchronously; mem_data goes to z; no rsp beat appears after reset release until a new request.
- Check for bus contention each cycle across a mixed write/read/write sequence → mem_data is never X, and the block's driver is enabled only while the RAM's output is disabled.

Source files
------------

// File: rtl/mem_master.sv
// Bus initiator for the 8-bit single-port RAM: single/burst read & fill-write with a registered response stream.
// Optional `define MEM_MASTER_WRAP_ERR_EN ends bursts at 0xFF and pulses err instead of wrapping silently.
module mem_master #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [7:0]       req_addr,
  input  logic [7:0]       req_wdata,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             err,
  output logic [7:0]       mem_addr,
  output logic             mem_we,
  output logic             mem_oe,
  inout  wire  [7:0]       mem_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN} state_t;

  state_t           state_r, state_s;
  logic [7:0]       addr_r, addr_s;
  logic [7:0]       wdata_r, wdata_s;
  logic [LEN_W-1:0] cnt_r, cnt_s;
  logic             wrap_s, final_s;
  logic             ready_r, busy_r, we_r, oe_r;
  logic             rd_pend_r, rd_last_r, rd_err_r;
  logic             rsp_valid_r, rsp_last_r, err_r;
  logic [7:0]       rsp_data_r;

  // Wrap detection: a beat at 0xFF with more beats still to go.
  always_comb begin
    wrap_s = 1'b0;
`ifdef MEM_MASTER_WRAP_ERR_EN
    if ((addr_r == 8'hFF) && (cnt_r != {LEN_W{1'b0}})) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
`else
    wrap_s = 1'b0;
`endif
    final_s = (cnt_r == {LEN_W{1'b0}}) || wrap_s;
  end

  // Next-state and burst datapath.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s = req_we ? ST_WRITE : ST_READ;
          addr_s  = req_addr;
          wdata_s = req_wdata;
          cnt_s   = req_len;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE, ST_READ: begin
        addr_s = addr_r + 8'd1;
        if (final_s) begin
          cnt_s   = {LEN_W{1'b0}};
          state_s = (state_r == ST_WRITE) ? ST_IDLE : ST_DRAIN;
        end else begin
          cnt_s   = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
          state_s = state_r;
        end
      end
      ST_DRAIN: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, burst registers and registered bus/handshake controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
      cnt_r   <= {LEN_W{1'b0}};
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      we_r    <= 1'b0;
      oe_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      cnt_r   <= cnt_s;
      ready_r <= (state_s == ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      we_r    <= (state_s == ST_WRITE);
      oe_r    <= (state_s == ST_READ) || (state_s == ST_DRAIN);
    end
  end

  // Read pipeline: the RAM latches at the end of an address cycle, we sample one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r   <= 1'b0;
      rd_last_r   <= 1'b0;
      rd_err_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_data_r  <= 8'h00;
      err_r       <= 1'b0;
    end else begin
      rd_pend_r   <= (state_r == ST_READ);
      rd_last_r   <= (state_r == ST_READ) && final_s;
      rd_err_r    <= (state_r == ST_READ) && wrap_s;
      rsp_valid_r <= rd_pend_r;
      rsp_last_r  <= rd_pend_r && rd_last_r;
      rsp_data_r  <= rd_pend_r ? mem_data : rsp_data_r;
      err_r       <= ((state_r == ST_WRITE) && wrap_s) || (rd_pend_r && rd_err_r);
    end
  end

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign mem_addr  = addr_r;
  assign mem_we    = we_r;
  assign mem_oe    = oe_r;
  assign mem_data  = we_r ? wdata_r : 8'bzzzz_zzzz;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_last  = rsp_last_r;
  assign err       = err_r;

endmodule

// File: tb/tb_mem_master.sv
// Randomized bench for mem_master with a behavioural RAM and a queue-based reference model.
// Follows `MEM_MASTER_WRAP_ERR_EN the same way the design build does.
module tb_mem_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic [3:0] req_len = 4'h0;
  logic       rsp_valid, rsp_last, busy, err, mem_we, mem_oe;
  logic [7:0] rsp_data, mem_addr;
  wire  [7:0] mem_data;

  mem_master #(.LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .err(err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle registered read.
  logic [7:0] ram [0:255];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    ram_q <= ram[mem_addr];
  end
  assign mem_data = (mem_oe && !mem_we) ? ram_q : 8'bzzzz_zzzz;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
    logic       err;
    int         cyc;
  } beat_t;

  beat_t      wr_q[$];
  beat_t      rd_addr_q[$];
  beat_t      rsp_q[$];
  logic [7:0] ref_mem [0:255];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         last_wait = 0;
  logic       err_due = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle monitor: write beats, read address beats, response stream, err, bus hygiene.
  always @(negedge clk) begin
    beat_t b;
    logic  err_exp, err_next;
    err_exp  = err_due;
    err_next = 1'b0;
    check_eq("we_oe_excl", {31'd0, mem_we & mem_oe}, 32'd0);
    if (mem_we || mem_oe) check_eq("bus_known", {31'd0, $isunknown(mem_data)}, 32'd0);
    else                  check_eq("bus_released", {31'd0, mem_data === 8'bzzzz_zzzz}, 32'd1);
    if (mem_we) begin
      if (wr_q.size() == 0) check_eq("wr_extra", 32'd1, 32'd0);
      else begin
        b = wr_q.pop_front();
        check_eq("wr_addr", {24'd0, mem_addr}, {24'd0, b.addr});
        check_eq("wr_data", {24'd0, mem_data}, {24'd0, b.data});
        check_eq("wr_cyc", cyc, b.cyc);
        if (b.err) err_next = 1'b1;
      end
    end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
      b = wr_q.pop_front();
      check_eq("wr_missing", cyc, b.cyc - 1);
    end
    if (rd_addr_q.size() != 0 && rd_addr_q[0].cyc <= cyc) begin
      b = rd_addr_q.pop_front();
      check_eq("rd_ctl", {30'd0, mem_oe, mem_we}, 32'd2);
      check_eq("rd_addr", {24'd0, mem_addr}, {24'd0, b.addr});
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) check_eq("rsp_extra", 32'd1, 32'd0);
      else begin
        b = rsp_q.pop_front();
        check_eq("rsp_data", {24'd0, rsp_data}, {24'd0, b.data});
        check_eq("rsp_last", {31'd0, rsp_last}, {31'd0, b.last});
        check_eq("rsp_cyc", cyc, b.cyc);
        if (b.err) err_exp = 1'b1;
      end
    end else if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
      b = rsp_q.pop_front();
      check_eq("rsp_missing", cyc, b.cyc - 1);
    end
    check_eq("err", {31'd0, err}, {31'd0, err_exp});
    err_due = err_next;
  end

  // Present a request (caller is just past a negedge); returns one cycle after acceptance with valid still high.
  task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] data,
                      input logic [3:0] len, input int exp_wait);
    int         waited, acc, beats;
    logic [7:0] a;
    logic       stop;
    beat_t      e;
    req_we = we; req_addr = addr; req_wdata = data; req_len = len; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 60) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!req_ready) begin
      check_eq("req_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (exp_wait >= 0) check_eq("ready_gap", waited, exp_wait);
    acc = cyc + 1;
    a = addr; beats = 0; stop = 1'b0;
    for (int i = 0; i <= int'(len) && !stop; i++) begin
      e.addr = a; e.cyc = acc + i; e.err = 1'b0; e.last = (i == int'(len));
`ifdef MEM_MASTER_WRAP_ERR_EN
      if (a == 8'hFF && i < int'(len)) begin
        e.err = 1'b1; e.last = 1'b1; stop = 1'b1;
      end
`endif
      if (we) begin
        e.data = data;
        ref_mem[a] = data;
        wr_q.push_back(e);
      end else begin
        e.data = ref_mem[a];
        rd_addr_q.push_back(e);
        e.cyc = acc + 2 + i;
        rsp_q.push_back(e);
      end
      a = a + 8'd1;
      beats++;
    end
    last_wait = we ? beats : beats + 1;
    @(negedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (n < 100 && (busy || rsp_q.size() != 0 || wr_q.size() != 0 || err_due)) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("idle_reached", {31'd0, busy}, 32'd0);
    check_eq("queues_empty", rsp_q.size() + wr_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] ra;
    #12;
    check_eq("rst_ctl", {26'd0, mem_we, mem_oe, rsp_valid, rsp_last, err, busy}, 32'd0);
    check_eq("rst_addr_data", {16'd0, mem_addr, rsp_data}, 32'd0);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_bus_z", {31'd0, mem_data === 8'bzzzz_zzzz}, 32'd1);
    @(negedge clk); rst_n = 1'b1; #1;

    // Fill the whole RAM so every later read has a known model value.
    for (int b = 0; b < 16; b++) begin
      send(1'b1, 8'(b * 16), 8'($urandom), 4'hF, -1);
      wait_idle();
    end

    send(1'b1, 8'h10, 8'hAB, 4'd0, -1); wait_idle();
    send(1'b0, 8'h10, 8'h00, 4'd0, -1); wait_idle();
    send(1'b1, 8'h20, 8'h5A, 4'd3, -1); wait_idle();
    send(1'b0, 8'h20, 8'h00, 4'd3, -1); wait_idle();

    send(1'b1, 8'hFE, 8'd1, 4'd0, -1); wait_idle();
    send(1'b1, 8'hFF, 8'd2, 4'd0, -1); wait_idle();
    send(1'b1, 8'h00, 8'd3, 4'd0, -1); wait_idle();
    send(1'b1, 8'h01, 8'd4, 4'd0, -1); wait_idle();
    send(1'b0, 8'hFE, 8'h00, 4'd3, -1); wait_idle();
    send(1'b1, 8'hFD, 8'hC3, 4'd4, -1); wait_idle();

    // Valid held through a long read; the next request must wait out READ and DRAIN.
    send(1'b0, 8'h40, 8'h00, 4'd7, -1);
    send(1'b1, 8'h50, 8'h77, 4'd2, 9);
    send(1'b0, 8'h50, 8'h00, 4'd2, last_wait);
    wait_idle();

    // Asynchronous reset in the middle of an 8-beat read.
    send(1'b0, 8'h60, 8'h00, 4'd7, -1);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    wr_q.delete(); rd_addr_q.delete(); rsp_q.delete(); err_due = 1'b0;
    #1;
    check_eq("arst_ctl", {28'd0, mem_oe, mem_we, rsp_valid, busy}, 32'd0);
    check_eq("arst_bus_z", {31'd0, mem_data === 8'bzzzz_zzzz}, 32'd1);
    @(negedge clk); rst_n = 1'b1; #1;
    repeat (6) @(negedge clk);
    #1;
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        send(1'($urandom), ra, 8'($urandom), 4'($urandom), -1);
      end else begin
        send(1'($urandom), ra, 8'($urandom), 4'($urandom), (i == 0) ? -1 : last_wait);
      end
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
